// File: rtl/ddr2_v10_1_sequencer_cpu_oci_access_scheduler.sv
// Shares the single-port OCI debug RAM between queued JTAG debug commands and the
// CPU Avalon debug slave, with round-robin arbitration when both request.
module ddr2_v10_1_sequencer_cpu_oci_access_scheduler #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic              avs_waitrequest,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [31:0]       ram_rdata
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {CMD_LOAD = 2'd0, CMD_WRITE = 2'd1, CMD_READ = 2'd2} cmd_e;
  typedef enum logic {GRANT_CPU = 1'b0, GRANT_JTAG = 1'b1} grant_e;

  cmd_e              fifo_cmd  [FIFO_DEPTH];
  logic [31:0]       fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] jaddr;
  grant_e            last_grant;
  logic              ret_valid;
  logic              ret_cpu;

  cmd_e        head_cmd;
  logic [31:0] head_data;
  cmd_e        push_cmd;
  logic [31:0] push_data;
  logic        empty, full, head_load;
  logic        jtag_req, cpu_req, jtag_grant, cpu_grant;
  logic        pop, take_any, push, collision, overflow;
  logic        unused_jdo;

  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign head_cmd  = fifo_cmd[rd_ptr];
  assign head_data = fifo_data[rd_ptr];
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign head_load = !empty && (head_cmd == CMD_LOAD);

  // JTAG always wins the first contention because last_grant resets to CPU
  assign jtag_req   = !empty && (head_cmd != CMD_LOAD);
  assign cpu_req    = avs_read | avs_write;
  assign jtag_grant = jtag_req && (!cpu_req || last_grant == GRANT_CPU);
  assign cpu_grant  = cpu_req && !jtag_grant;

  // A pop frees its slot before the same-cycle push is judged
  assign pop       = head_load || jtag_grant;
  assign take_any  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign push      = take_any && (!full || pop);
  assign overflow  = take_any && full && !pop;
  assign collision = (take_action_ocimem_a && (take_action_ocimem_b || take_no_action_ocimem_a))
                   || (take_action_ocimem_b && take_no_action_ocimem_a);

  // Priority select of the captured command
  always_comb begin
    push_cmd  = CMD_LOAD;
    push_data = '0;
    if (take_action_ocimem_a) begin
      push_cmd  = CMD_LOAD;
      push_data = 32'(jdo[ADDR_W+16:17]);
    end else if (take_action_ocimem_b) begin
      push_cmd  = CMD_WRITE;
      push_data = jdo[34:3];
    end else if (take_no_action_ocimem_a) begin
      push_cmd  = CMD_READ;
    end
  end

  // RAM port mux for the granted requester
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    if (jtag_grant) begin
      ram_addr = jaddr;
      if (head_cmd == CMD_WRITE) begin
        ram_we    = 1'b1;
        ram_wdata = head_data;
      end else begin
        ram_re = 1'b1;
      end
    end else if (cpu_grant) begin
      ram_addr  = avs_address;
      ram_wdata = avs_writedata;
      ram_we    = avs_write;
      ram_re    = avs_read && !avs_write;
    end
  end

  assign avs_waitrequest   = cpu_req && !cpu_grant;
  assign avs_readdatavalid = ret_valid && ret_cpu;
  assign avs_readdata      = avs_readdatavalid ? ram_rdata : '0;

  // Command storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_cmd[wr_ptr]  <= push_cmd;
      fifo_data[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      jaddr         <= '0;
      last_grant    <= GRANT_CPU;
      ret_valid     <= 1'b0;
      ret_cpu       <= 1'b0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);

      if (head_load)       jaddr <= head_data[ADDR_W-1:0];
      else if (jtag_grant) jaddr <= jaddr + ADDR_W'(1);

      if (jtag_grant)     last_grant <= GRANT_JTAG;
      else if (cpu_grant) last_grant <= GRANT_CPU;

      ret_valid <= ram_re;
      ret_cpu   <= cpu_grant;

      if (ret_valid && !ret_cpu) MonDReg <= ram_rdata;

      // A LOAD executes after any earlier read, so its clear takes precedence
      if (head_load)                  monitor_ready <= 1'b0;
      else if (ret_valid && !ret_cpu) monitor_ready <= 1'b1;

      if (collision || overflow) monitor_error <= 1'b1;
      else if (head_load)        monitor_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ddr2_v10_1_sequencer_cpu_oci_access_scheduler.sv
// Directed bench for the OCI RAM access scheduler with a behavioural RAM model.
module tb_ddr2_v10_1_sequencer_cpu_oci_access_scheduler;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_a, take_b, take_na;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we, ram_re;
  logic [31:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ddr2_v10_1_sequencer_cpu_oci_access_scheduler #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_a), .take_action_ocimem_b(take_b),
    .take_no_action_ocimem_a(take_na),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_waitrequest(avs_waitrequest),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata)
  );

  // RAM model: unwritten words read back as C0FFEE_<addr>
  logic [31:0]  mem [256];
  logic [255:0] written;
  always @(posedge clk) begin
    if (!reset_n) begin
      written <= '0;
    end else begin
      if (ram_we) begin
        mem[ram_addr]     <= ram_wdata;
        written[ram_addr] <= 1'b1;
      end
      if (ram_re) ram_rdata <= written[ram_addr] ? mem[ram_addr] : {24'hC0FFEE, ram_addr};
    end
  end

  function automatic logic [37:0] jdo_addr(input logic [7:0] a);
    logic [37:0] v;
    v = '0;
    v[24:17] = a;
    return v;
  endfunction

  function automatic logic [37:0] jdo_data(input logic [31:0] d);
    logic [37:0] v;
    v = '0;
    v[34:3] = d;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    take_a  = 1'b0;
    take_b  = 1'b0;
    take_na = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; jdo = '0; take_a = 0; take_b = 0; take_na = 0;
    avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0;
    step(); step();
    @(negedge clk);
    checks++;
    if (MonDReg !== 32'h0 || monitor_ready !== 1'b0 || monitor_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_monitor: MonDReg=%h ready=%b error=%b, expected 0/0/0", MonDReg, monitor_ready, monitor_error);
    end
    checks++;
    if (avs_readdatavalid !== 1'b0 || avs_waitrequest !== 1'b0 || ram_we !== 1'b0 || ram_re !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: rdv=%b wait=%b we=%b re=%b, expected all 0", avs_readdatavalid, avs_waitrequest, ram_we, ram_re);
    end
    reset_n = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b0 || ram_re !== 1'b0 || avs_waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: we=%b re=%b wait=%b, expected 0", ram_we, ram_re, avs_waitrequest);
    end
    step();
  endtask

  task automatic test_load_write();
    jdo = jdo_addr(8'h10); take_a = 1; step();
    jdo = jdo_data(32'hDEADBEEF); take_b = 1;
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b0 || ram_re !== 1'b0) begin
      errors++;
      $display("FAIL load_no_ram: we=%b re=%b, expected 0/0", ram_we, ram_re);
    end
    step();
    jdo = jdo_data(32'h12345678); take_b = 1;
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b1 || ram_re !== 1'b0 || ram_addr !== 8'h10 || ram_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write1: we=%b re=%b addr=%h data=%h, expected 1/0/10/deadbeef", ram_we, ram_re, ram_addr, ram_wdata);
    end
    step();
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 8'h11 || ram_wdata !== 32'h12345678) begin
      errors++;
      $display("FAIL write2: we=%b addr=%h data=%h, expected 1/11/12345678", ram_we, ram_addr, ram_wdata);
    end
    step();
    take_na = 1; step();
    @(negedge clk);
    checks++;
    if (ram_re !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 8'h12) begin
      errors++;
      $display("FAIL jaddr_after_writes: re=%b we=%b addr=%h, expected 1/0/12", ram_re, ram_we, ram_addr);
    end
    step(); step();
    @(negedge clk);
    checks++;
    if (monitor_ready !== 1'b1 || MonDReg !== 32'hC0FFEE12) begin
      errors++;
      $display("FAIL read_12: ready=%b MonDReg=%h, expected 1/c0ffee12", monitor_ready, MonDReg);
    end
    step();
  endtask

  task automatic test_load_read();
    jdo = jdo_addr(8'h10); take_a = 1; step();
    take_na = 1; step();
    @(negedge clk);
    checks++;
    if (ram_re !== 1'b1 || ram_addr !== 8'h10 || monitor_ready !== 1'b0) begin
      errors++;
      $display("FAIL read_issue: re=%b addr=%h ready=%b, expected 1/10/0", ram_re, ram_addr, monitor_ready);
    end
    step();
    @(negedge clk);
    checks++;
    if (monitor_ready !== 1'b0) begin
      errors++;
      $display("FAIL read_early: ready=%b, expected 0", monitor_ready);
    end
    step();
    @(negedge clk);
    checks++;
    if (monitor_ready !== 1'b1 || MonDReg !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_result: ready=%b MonDReg=%h, expected 1/deadbeef", monitor_ready, MonDReg);
    end
    step();
  endtask

  task automatic test_wrap();
    jdo = jdo_addr(8'hFF); take_a = 1; step();
    take_na = 1; step();
    take_na = 1;
    @(negedge clk);
    checks++;
    if (ram_re !== 1'b1 || ram_addr !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_read_ff: re=%b addr=%h, expected 1/ff", ram_re, ram_addr);
    end
    step();
    @(negedge clk);
    checks++;
    if (ram_re !== 1'b1 || ram_addr !== 8'h00) begin
      errors++;
      $display("FAIL wrap_read_00: re=%b addr=%h, expected 1/00", ram_re, ram_addr);
    end
    step();
    @(negedge clk);
    checks++;
    if (MonDReg !== 32'hC0FFEEFF) begin
      errors++;
      $display("FAIL wrap_data_ff: MonDReg=%h, expected c0ffeeff", MonDReg);
    end
    step();
    @(negedge clk);
    checks++;
    if (MonDReg !== 32'hC0FFEE00 || monitor_ready !== 1'b1) begin
      errors++;
      $display("FAIL wrap_data_00: MonDReg=%h ready=%b, expected c0ffee00/1", MonDReg, monitor_ready);
    end
    step();
  endtask

  task automatic test_cpu_rw();
    avs_address = 8'h30; avs_writedata = 32'h55AA55AA; avs_write = 1;
    @(negedge clk);
    checks++;
    if (avs_waitrequest !== 1'b0 || ram_we !== 1'b1 || ram_re !== 1'b0 || ram_addr !== 8'h30 || ram_wdata !== 32'h55AA55AA) begin
      errors++;
      $display("FAIL cpu_write: wait=%b we=%b re=%b addr=%h data=%h, expected 0/1/0/30/55aa55aa", avs_waitrequest, ram_we, ram_re, ram_addr, ram_wdata);
    end
    step();
    avs_write = 0; avs_read = 1;
    @(negedge clk);
    checks++;
    if (avs_waitrequest !== 1'b0 || ram_re !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 8'h30) begin
      errors++;
      $display("FAIL cpu_read_issue: wait=%b re=%b we=%b addr=%h, expected 0/1/0/30", avs_waitrequest, ram_re, ram_we, ram_addr);
    end
    step();
    avs_read = 0;
    @(negedge clk);
    checks++;
    if (avs_readdatavalid !== 1'b1 || avs_readdata !== 32'h55AA55AA) begin
      errors++;
      $display("FAIL cpu_read_data: rdv=%b data=%h, expected 1/55aa55aa", avs_readdatavalid, avs_readdata);
    end
    checks++;
    if (MonDReg !== 32'hC0FFEE00 || monitor_ready !== 1'b1) begin
      errors++;
      $display("FAIL cpu_tag_isolation: MonDReg=%h ready=%b, expected c0ffee00/1", MonDReg, monitor_ready);
    end
    step();
    @(negedge clk);
    checks++;
    if (avs_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL cpu_rdv_single: rdv=%b, expected 0", avs_readdatavalid);
    end
    step();
  endtask

  task automatic test_alternate();
    logic       exp_j;
    logic [7:0] exp_addr;
    jdo = jdo_addr(8'h40); take_a = 1; step(); step();
    avs_address = 8'h20; avs_read = 1; step();
    for (int c = 1; c <= 9; c++) begin
      if (c <= 4) begin
        jdo = jdo_data(32'hA000_0000 + 32'(c)); take_b = 1;
      end
      if (c >= 2) begin
        @(negedge clk);
        exp_j    = (c % 2 == 0);
        exp_addr = exp_j ? 8'(8'h40 + c / 2 - 1) : 8'h20;
        checks++;
        if (ram_we !== exp_j || ram_re !== !exp_j || avs_waitrequest !== exp_j || ram_addr !== exp_addr
            || (exp_j && ram_wdata !== 32'hA000_0000 + 32'(c / 2))) begin
          errors++;
          $display("FAIL alternate_c%0d: we=%b re=%b wait=%b addr=%h data=%h, expected we=%b addr=%h", c, ram_we, ram_re, avs_waitrequest, ram_addr, ram_wdata, exp_j, exp_addr);
        end
      end
      step();
    end
    avs_read = 0;
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b0 || ram_re !== 1'b0 || avs_waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL alternate_drained: we=%b re=%b wait=%b, expected 0/0/0", ram_we, ram_re, avs_waitrequest);
    end
    step();
  endtask

  task automatic test_overflow();
    jdo = jdo_addr(8'h80); take_a = 1; step(); step();
    avs_address = 8'h21; avs_read = 1; step();
    for (int c = 1; c <= 9; c++) begin
      jdo = jdo_data(32'hB0 + 32'(c)); take_b = 1;
      if (c == 9) begin
        @(negedge clk);
        checks++;
        if (monitor_error !== 1'b0) begin
          errors++;
          $display("FAIL full_push_with_pop: error=%b, expected 0", monitor_error);
        end
      end
      step();
    end
    avs_read = 0; jdo = jdo_addr(8'h00); take_a = 1;
    @(negedge clk);
    checks++;
    if (monitor_error !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'h84 || ram_wdata !== 32'hB5) begin
      errors++;
      $display("FAIL overflow_flag: error=%b we=%b addr=%h data=%h, expected 1/1/84/b5", monitor_error, ram_we, ram_addr, ram_wdata);
    end
    step(); step();
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 8'h86 || ram_wdata !== 32'hB7) begin
      errors++;
      $display("FAIL overflow_drain: we=%b addr=%h data=%h, expected 1/86/b7", ram_we, ram_addr, ram_wdata);
    end
    step(); step();
    @(negedge clk);
    checks++;
    if (monitor_error !== 1'b1 || ram_we !== 1'b0 || ram_re !== 1'b0) begin
      errors++;
      $display("FAIL overflow_load_exec: error=%b we=%b re=%b, expected 1/0/0", monitor_error, ram_we, ram_re);
    end
    step();
    @(negedge clk);
    checks++;
    if (monitor_error !== 1'b0) begin
      errors++;
      $display("FAIL overflow_cleared: error=%b, expected 0", monitor_error);
    end
    step();
  endtask

  task automatic test_reset_midop();
    jdo = jdo_data(32'hCAFE0000); take_b = 1; take_na = 1; step();
    avs_address = 8'h05; avs_read = 1;
    @(negedge clk);
    checks++;
    if (avs_waitrequest !== 1'b0 || ram_re !== 1'b1 || ram_addr !== 8'h05 || monitor_error !== 1'b1 || MonDReg !== 32'hC0FFEE00) begin
      errors++;
      $display("FAIL pre_reset: wait=%b re=%b addr=%h error=%b MonDReg=%h, expected 0/1/05/1/c0ffee00", avs_waitrequest, ram_re, ram_addr, monitor_error, MonDReg);
    end
    reset_n = 1'b0; avs_read = 0;
    #1;
    checks++;
    if (MonDReg !== 32'h0 || monitor_ready !== 1'b0 || monitor_error !== 1'b0 || avs_readdatavalid !== 1'b0
        || ram_we !== 1'b0 || ram_re !== 1'b0 || avs_waitrequest !== 1'b0 || avs_readdata !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: MonDReg=%h ready=%b error=%b rdv=%b we=%b re=%b wait=%b, expected all 0", MonDReg, monitor_ready, monitor_error, avs_readdatavalid, ram_we, ram_re, avs_waitrequest);
    end
    @(posedge clk); #1;
    checks++;
    if (avs_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard_return: rdv=%b, expected 0", avs_readdatavalid);
    end
    step();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (ram_we !== 1'b0 || ram_re !== 1'b0 || avs_readdatavalid !== 1'b0 || monitor_error !== 1'b0) begin
        errors++;
        $display("FAIL fifo_flushed_c%0d: we=%b re=%b rdv=%b error=%b, expected 0", c, ram_we, ram_re, avs_readdatavalid, monitor_error);
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_write();
    test_load_read();
    test_wrap();
    test_cpu_rw();
    test_alternate();
    test_overflow();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
